// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the external memory port that the
// arbiter multiplexes between them.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Port 0: instruction-cache refill engine (read-only)
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  ready0;

    // Port 1: data-cache refill/writeback engine (read/write)
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ready1;

    // Shared read data, broadcast to both requesters
    logic [DATA_WIDTH-1:0] rdata;

    // External memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    // Requesters and memory model side
    modport master (
        output req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_ready,
        input  ready0, ready1, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_ready,
        output ready0, ready1, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Burst-granting round-robin arbiter sharing one memory port between the
// icache refill engine (port 0) and the dcache refill/writeback engine
// (port 1), with per-port grant and wait-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int CNT_BITS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]  owner,
    output logic [31:0] grant_count0,
    output logic [31:0] grant_count1,
    output logic [31:0] wait_cycles0,
    output logic [31:0] wait_cycles1
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic                last_owner_q, last_owner_d;
    logic [31:0]         grant_count0_q, grant_count0_d;
    logic [31:0]         grant_count1_q, grant_count1_d;
    logic [31:0]         wait_cycles0_q, wait_cycles0_d;
    logic [31:0]         wait_cycles1_q, wait_cycles1_d;

    // State, beat counter, round-robin pointer and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            last_owner_q   <= 1'b1;
            grant_count0_q <= '0;
            grant_count1_q <= '0;
            wait_cycles0_q <= '0;
            wait_cycles1_q <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            last_owner_q   <= last_owner_d;
            grant_count0_q <= grant_count0_d;
            grant_count1_q <= grant_count1_d;
            wait_cycles0_q <= wait_cycles0_d;
            wait_cycles1_q <= wait_cycles1_d;
        end
    end

    // Arbitration, burst tracking and counter updates
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        last_owner_d   = last_owner_q;
        grant_count0_d = grant_count0_q;
        grant_count1_d = grant_count1_q;
        wait_cycles0_d = wait_cycles0_q + 32'(bus.req0 && (state_q != OWN0));
        wait_cycles1_d = wait_cycles1_q + 32'(bus.req1 && (state_q != OWN1));

        unique case (state_q)
            IDLE: begin
                // last_owner == 1 means port 0 wins a tie, and vice versa
                if (bus.req0 && (!bus.req1 || last_owner_q)) begin
                    state_d        = OWN0;
                    beat_cnt_d     = '0;
                    grant_count0_d = grant_count0_q + 32'd1;
                end else if (bus.req1) begin
                    state_d        = OWN1;
                    beat_cnt_d     = '0;
                    grant_count1_d = grant_count1_q + 32'd1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                    beat_cnt_d   = '0;
                end else if (bus.mem_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        last_owner_d = 1'b0;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                    beat_cnt_d   = '0;
                end else if (bus.mem_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        last_owner_d = 1'b1;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Memory-port mux driven purely by the current owner
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.ready0    = 1'b0;
        bus.ready1    = 1'b0;
        bus.rdata     = bus.mem_rdata;
        owner         = state_q;
        grant_count0  = grant_count0_q;
        grant_count1  = grant_count1_q;
        wait_cycles0  = wait_cycles0_q;
        wait_cycles1  = wait_cycles1_q;

        unique case (state_q)
            OWN0: begin
                bus.mem_req  = bus.req0;
                bus.mem_addr = bus.addr0;
                bus.ready0   = bus.mem_ready && bus.req0;
            end
            OWN1: begin
                bus.mem_req   = bus.req1;
                bus.mem_addr  = bus.addr1;
                bus.mem_we    = bus.we1;
                bus.mem_wdata = bus.wdata1;
                bus.ready1    = bus.mem_ready && bus.req1;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a behavioural ownership model.
module tb_mem_port_arbiter;
    localparam int BURST_LEN = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  owner;
    logic [31:0] grant_count0, grant_count1, wait_cycles0, wait_cycles1;

    int vectors;
    int miscompares;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BURST_LEN (BURST_LEN),
        .CNT_BITS  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .owner       (owner),
        .grant_count0(grant_count0),
        .grant_count1(grant_count1),
        .wait_cycles0(wait_cycles0),
        .wait_cycles1(wait_cycles1)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: who holds memory (0 none, 1 port0, 2 port1), how many
    // beats of the current burst are done, and which port wins the next tie
    int          m_holder;
    int          m_beats_done;
    bit          m_port0_wins_tie;
    logic [31:0] m_grants [2];
    logic [31:0] m_waits  [2];

    logic        e_mem_req, e_mem_we, e_ready0, e_ready1;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic [1:0]  e_owner;

    task automatic model_clock();
        bit r [2];
        r[0] = bus.req0;
        r[1] = bus.req1;
        if (reset) begin
            m_holder = 0; m_beats_done = 0; m_port0_wins_tie = 1'b1;
            m_grants[0] = 0; m_grants[1] = 0; m_waits[0] = 0; m_waits[1] = 0;
            return;
        end
        for (int p = 0; p < 2; p++)
            if (r[p] && m_holder != p + 1) m_waits[p] = m_waits[p] + 1;
        if (m_holder == 0) begin
            if (r[0] && (!r[1] || m_port0_wins_tie)) begin
                m_holder = 1; m_grants[0] = m_grants[0] + 1; m_beats_done = 0;
            end else if (r[1]) begin
                m_holder = 2; m_grants[1] = m_grants[1] + 1; m_beats_done = 0;
            end
        end else begin
            int p = m_holder - 1;
            if (!r[p]) begin
                m_holder = 0; m_port0_wins_tie = (p == 1);
            end else if (bus.mem_ready) begin
                m_beats_done++;
                if (m_beats_done == BURST_LEN) begin
                    m_holder = 0; m_port0_wins_tie = (p == 1); m_beats_done = 0;
                end
            end
        end
    endtask

    task automatic compute_expected();
        e_mem_req = 0; e_mem_we = 0; e_ready0 = 0; e_ready1 = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_owner = 2'(m_holder);
        if (m_holder == 1) begin
            e_mem_req = bus.req0; e_mem_addr = bus.addr0;
            e_ready0 = bus.mem_ready & bus.req0;
        end else if (m_holder == 2) begin
            e_mem_req = bus.req1; e_mem_addr = bus.addr1;
            e_mem_we = bus.we1; e_mem_wdata = bus.wdata1;
            e_ready1 = bus.mem_ready & bus.req1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive_idle();
        bus.req0 = 0; bus.addr0 = 0; bus.req1 = 0; bus.we1 = 0;
        bus.addr1 = 0; bus.wdata1 = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.mem_ready = 1;
        apply_reset();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ready0, bus.ready1, owner} !== 70'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rdy0=%b rdy1=%b owner=%0d, want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ready0, bus.ready1, owner);
        end
        vectors++;
        if ({grant_count0, grant_count1, wait_cycles0, wait_cycles1} !== 128'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: got %h %h %h %h, want 0", grant_count0, grant_count1, wait_cycles0, wait_cycles1);
        end
    endtask

    task automatic test_single_burst();
        int pulses = 0;
        apply_reset();
        bus.req0 = 1; bus.addr0 = 32'h100;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL grant_latency: mem_req=%b, want 0 in arbitration cycle", bus.mem_req);
        end
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || owner !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL grant_port0: req=%b addr=%h owner=%0d, want 1 00000100 1", bus.mem_req, bus.mem_addr, owner);
        end
        for (int b = 0; b < 2 * BURST_LEN - 1; b++) begin
            bus.mem_ready = (b % 2 == 0);
            #1;
            vectors++;
            if (bus.ready0 !== bus.mem_ready || bus.ready1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ready0_mirror: cycle %0d ready0=%b ready1=%b, want %b 0", b, bus.ready0, bus.ready1, bus.mem_ready);
            end
            if (bus.ready0 === 1'b1) pulses++;
            tick();
        end
        bus.mem_ready = 0;
        #1;
        vectors++;
        if (owner !== 2'd0 || grant_count0 !== 32'd1 || pulses != BURST_LEN) begin
            miscompares++;
            $display("[TB] FAIL burst_end: owner=%0d grants0=%0d pulses=%0d, want 0 1 %0d", owner, grant_count0, pulses, BURST_LEN);
        end
        bus.req0 = 0;
    endtask

    task automatic test_tie();
        apply_reset();
        bus.req0 = 1; bus.req1 = 1; bus.mem_ready = 1;
        tick();
        vectors++;
        if (owner !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL tie_first: owner=%0d, want 1", owner);
        end
        for (int b = 0; b < BURST_LEN; b++) tick();
        vectors++;
        if (owner !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL tie_dead_cycle: owner=%0d, want 0", owner);
        end
        tick();
        vectors++;
        if (owner !== 2'd2 || wait_cycles1 !== 32'd6 || wait_cycles0 !== m_waits[0]) begin
            miscompares++;
            $display("[TB] FAIL tie_second: owner=%0d wait1=%0d wait0=%0d, want 2 6 %0d", owner, wait_cycles1, wait_cycles0, m_waits[0]);
        end
        drive_idle();
    endtask

    task automatic test_alternate();
        int seq [$];
        int prev = 0;
        int bad_ready1 = 0;
        apply_reset();
        bus.req0 = 1; bus.req1 = 1; bus.mem_ready = 1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (owner == 2'd1 && bus.ready1 !== 1'b0) bad_ready1++;
            if (prev == 0 && owner != 2'd0) seq.push_back(int'(owner));
            prev = int'(owner);
            tick();
        end
        vectors++;
        if (seq.size() < 3 || seq[0] != 1 || seq[1] != 2 || seq[2] != 1) begin
            miscompares++;
            $display("[TB] FAIL alternate_seq: got %p, want 1 2 1 first", seq);
        end
        vectors++;
        if (bad_ready1 != 0) begin
            miscompares++;
            $display("[TB] FAIL ready1_in_own0: %0d cycles with ready1 high, want 0", bad_ready1);
        end
        vectors++;
        if (grant_count0 !== m_grants[0] || grant_count1 !== m_grants[1]) begin
            miscompares++;
            $display("[TB] FAIL alternate_grants: got %0d %0d, want %0d %0d", grant_count0, grant_count1, m_grants[0], m_grants[1]);
        end
        drive_idle();
    endtask

    task automatic test_write_burst();
        int pulses = 0;
        apply_reset();
        bus.req1 = 1; bus.we1 = 1; bus.wdata1 = 32'hDEADBEEF; bus.addr1 = $urandom;
        tick();
        bus.mem_ready = 1;
        for (int b = 0; b < BURST_LEN; b++) begin
            bus.addr1 = bus.addr1 + 4;
            #1;
            vectors++;
            if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_addr !== bus.addr1 || bus.ready1 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL write_beat%0d: we=%b wdata=%h addr=%h ready1=%b, want 1 deadbeef %h 1",
                         b, bus.mem_we, bus.mem_wdata, bus.mem_addr, bus.ready1, bus.addr1);
            end
            if (bus.ready1 === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses != BURST_LEN || owner !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL write_burst_end: pulses=%0d owner=%0d, want %0d 0", pulses, owner, BURST_LEN);
        end
        drive_idle();
    endtask

    task automatic test_early_drop();
        apply_reset();
        bus.req0 = 1; bus.req1 = 1;
        tick();
        bus.mem_ready = 1;
        tick();
        tick();
        bus.req0 = 0;
        #1;
        vectors++;
        if (bus.ready0 !== 1'b0 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_no_ready: ready0=%b mem_req=%b, want 0 0", bus.ready0, bus.mem_req);
        end
        tick();
        vectors++;
        if (owner !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL drop_idle: owner=%0d, want 0", owner);
        end
        tick();
        vectors++;
        if (owner !== 2'd2 || grant_count1 !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL drop_regrant: owner=%0d grants1=%0d, want 2 1", owner, grant_count1);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        bus.req1 = 1;
        tick();
        bus.mem_ready = 1;
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        vectors++;
        if (owner !== 2'd0 || bus.mem_req !== 1'b0 || bus.ready1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: owner=%0d mem_req=%b ready1=%b, want 0 0 0", owner, bus.mem_req, bus.ready1);
        end
        vectors++;
        if ({grant_count0, grant_count1, wait_cycles0, wait_cycles1} !== 128'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_counters: got %h %h %h %h, want 0", grant_count0, grant_count1, wait_cycles0, wait_cycles1);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [69:0]  act, exp;
        logic [127:0] act_c, exp_c;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
            bus.we1       = 1'($urandom);
            bus.addr0     = $urandom;
            bus.addr1     = $urandom;
            bus.wdata1    = $urandom;
            bus.mem_rdata = $urandom;
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            reset         = ($urandom_range(0, 63) == 0);
            #1;
            compute_expected();
            act = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ready0, bus.ready1, owner};
            exp = {e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_ready0, e_ready1, e_owner};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("[TB] FAIL rand_bus cycle %0d: got %h, want %h", c, act, exp);
            end
            act_c = {grant_count0, grant_count1, wait_cycles0, wait_cycles1};
            exp_c = {m_grants[0], m_grants[1], m_waits[0], m_waits[1]};
            vectors++;
            if (act_c !== exp_c) begin
                miscompares++;
                $display("[TB] FAIL rand_counters cycle %0d: got %h, want %h", c, act_c, exp_c);
            end
            vectors++;
            if (bus.rdata !== bus.mem_rdata) begin
                miscompares++;
                $display("[TB] FAIL rand_rdata cycle %0d: got %h, want %h", c, bus.rdata, bus.mem_rdata);
            end
            tick();
        end
        reset = 0;
        drive_idle();
    endtask

    // Scenario sequence and summary
    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 0;
        m_holder = 0; m_beats_done = 0; m_port0_wins_tie = 1'b1;
        m_grants[0] = 0; m_grants[1] = 0; m_waits[0] = 0; m_waits[1] = 0;
        drive_idle();
        test_reset();
        test_single_burst();
        test_tie();
        test_alternate();
        test_write_burst();
        test_early_drop();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external instruction/data memory port between the instruction-cache refill engine (port 0, read-only) and the data-cache refill/writeback engine (port 1, read/write).
- Grants whole bursts: once a port owns memory, it keeps it until BURST_LEN beats complete or it drops its request.
- Ties are broken round-robin.
- Provides per-port grant and wait-cycle counters for the performance-monitor block.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- BURST_LEN, 4, beats per cache-line burst; legal values 1..16.
- CNT_BITS, 4, beat counter width; must satisfy 2^CNT_BITS >= BURST_LEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 (icache) memory request, held for whole burst
- addr0  in  ADDR_WIDTH  port 0 beat address
- ready0  out  1  port 0 beat accepted/data valid
- req1  in  1  port 1 (dcache) memory request
- we1  in  1  port 1 write enable (1 = write burst)
- addr1  in  ADDR_WIDTH  port 1 beat address
- wdata1  in  DATA_WIDTH  port 1 write data
- ready1  out  1  port 1 beat accepted/data valid
- rdata  out  DATA_WIDTH  read data, broadcast to both ports (equals mem_rdata)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory beat complete
- owner  out  2  0 = idle, 1 = port 0, 2 = port 1
- grant_count0, grant_count1  out  32  bursts granted per port
- wait_cycles0, wait_cycles1  out  32  cycles reqN high while not owner

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, beat_cnt (CNT_BITS), last_owner (1 bit), plus counters.
- Reset, synchronous: state = IDLE, beat_cnt = 0, last_owner = 1 (port 0 wins the first tie), all counters = 0. Resulting outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, ready0 = ready1 = 0, owner = 0.
- Reset mid-burst aborts the burst immediately: mem_req = 0 from the cycle after the reset edge, and no ready is issued.
- Output mux is combinational from state:
  - OWN0: mem_req = req0, mem_addr = addr0, mem_we = 0, mem_wdata = 0, ready0 = mem_ready.
  - OWN1: mem_req = req1, mem_addr = addr1, mem_we = we1, mem_wdata = wdata1, ready1 = mem_ready.
  - IDLE: all mem_* outputs and both readyN are 0.
  - rdata = mem_rdata at all times.
- A non-owner's readyN is always 0. mem_ready while IDLE is ignored.
- IDLE arbitration:
  - Only req0 high: next state OWN0.
  - Only req1 high: next state OWN1.
  - Both high: grant the port that is not last_owner.
  - Grant takes effect next cycle, so arbitration latency is 1 cycle from req to mem_req.
  - On grant: grant_countN += 1, beat_cnt = 0.
- In OWNn, on each cycle with mem_ready = 1 and reqN = 1:
  - If beat_cnt == BURST_LEN-1: state -> IDLE, last_owner = n, beat_cnt = 0.
  - Otherwise: beat_cnt += 1.
- In OWNn with reqN = 0 (early drop or abort): state -> IDLE, last_owner = n, beat_cnt = 0. No ready is issued in that cycle.
- Release always passes through IDLE for one dead cycle. Back-to-back bursts from the same port with no competitor therefore cost 1 cycle between bursts.
- Starvation bound: with both ports continuously requesting, ownership strictly alternates; maximum wait is one full burst plus 2 cycles.
- wait_cyclesN increments on every cycle where reqN = 1 and state != OWNn. This includes the IDLE arbitration cycle.
- All counters are 32-bit and wrap modulo 2^32 with no saturation.
- A change of we1 mid-burst is passed through unchanged; the arbiter does not check it.
- Address is a pass-through. The arbiter performs no address arithmetic; requesters advance their own addresses per beat.

Test Plan:
- Reset, then req0 = 1 with addr0 = 0x100: mem_req rises 1 cycle later with mem_addr = 0x100. With mem_ready pulsed 4 times, ready0 mirrors it; after the 4th beat owner = 0 and grant_count0 = 1.
- req0 and req1 rise in the same cycle after reset: port 0 is granted first (owner = 1). After its 4 beats, 1 idle cycle, then owner = 2. wait_cycles1 = 6 with 1-cycle-latency memory.
- Both ports requesting continuously for 3 bursts: owner sequence 1, 2, 1. ready1 = 0 throughout every OWN0 cycle.
- Port 1 write burst (we1 = 1, wdata1 = 0xDEADBEEF): mem_we = 1 and mem_wdata = 0xDEADBEEF on every beat. ready1 pulses 4 times.
- Early drop: req0 falls after 2 beats → IDLE next cycle with beat_cnt = 0; a pending req1 is then granted.
- Reset asserted during beat 2 of an OWN1 burst → next cycle owner = 0, mem_req = 0, all counters = 0, ready1 = 0.
